// File: rtl/mem_dc_sequencer.sv
// ---------------------------------------------------------------------------
// mem_dc_sequencer
//   Data-counter (DC) memory sequencer. It holds DC_COUNT address counters,
//   each with a direction flag and a sticky "modified" flag. It runs one
//   memory operation at a time over a valid/ready request port, with at most
//   one read response outstanding. It also supports multi-beat burst reads.
//
//   Optional feature macro: DC_STRIDE_EN
//     When defined, each counter has its own stride register. SETF and SETB
//     load the stride from op_data[STRIDE_WIDTH-1:0]; a value of 0 is stored
//     as 1. When undefined, every counter steps by 1.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   op_valid/op_ready        operation handshake (ready only in IDLE)
//   op_code/op_sel           opcode and counter index
//   op_addr/op_data          absolute address; write data / burst length / stride
//   mem_req_*                registered memory request (held until ready)
//   mem_rsp_valid/_data      read response (only sampled while waiting for it)
//   rd_valid/rd_data         one-cycle registered read-data strobe
//   dc_addr/dc_dir/dc_mod    counter state; counter i sits at [i*ADDR_WIDTH +: ADDR_WIDTH]
// ---------------------------------------------------------------------------
module mem_dc_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int WORD_WIDTH   = 32,
  parameter int DC_COUNT     = 4,
  parameter int BURST_WIDTH  = 8,
  parameter int STRIDE_WIDTH = 4,
  parameter int SEL_W        = $clog2(DC_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           op_valid,
  output logic                           op_ready,
  input  logic [2:0]                     op_code,
  input  logic [SEL_W-1:0]               op_sel,
  input  logic [ADDR_WIDTH-1:0]          op_addr,
  input  logic [WORD_WIDTH-1:0]          op_data,
  output logic                           mem_req_valid,
  input  logic                           mem_req_ready,
  output logic                           mem_req_write,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr,
  output logic [WORD_WIDTH-1:0]          mem_req_wdata,
  input  logic                           mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0]          mem_rsp_data,
  output logic                           rd_valid,
  output logic [WORD_WIDTH-1:0]          rd_data,
  output logic [DC_COUNT*ADDR_WIDTH-1:0] dc_addr,
  output logic [DC_COUNT-1:0]            dc_dir,
  output logic [DC_COUNT-1:0]            dc_mod
);

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_WRITE  = 3'd2;
  localparam logic [2:0] OP_SETF   = 3'd3;
  localparam logic [2:0] OP_SETB   = 3'd4;
  localparam logic [2:0] OP_RREAD  = 3'd5;
  localparam logic [2:0] OP_RWRITE = 3'd6;
  localparam logic [2:0] OP_BURST  = 3'd7;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_RSP = 2'd2} state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_dc [DC_COUNT];
  logic [DC_COUNT-1:0]     r_dir;
  logic [DC_COUNT-1:0]     r_mod;
  logic                    r_req_valid;
  logic                    r_req_write;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic [WORD_WIDTH-1:0]   r_req_wdata;
  logic                    r_rd_valid;
  logic [WORD_WIDTH-1:0]   r_rd_data;
  logic [BURST_WIDTH-1:0]  r_burst_cnt;   // beats still to issue after the current one
  logic [SEL_W-1:0]        r_sel;         // counter that owns the running burst

  logic                    w_sel_ok;
  logic [ADDR_WIDTH-1:0]   w_dc_op;
  logic [ADDR_WIDTH-1:0]   w_step_op;
  logic [ADDR_WIDTH-1:0]   w_step_burst;
  logic [ADDR_WIDTH-1:0]   w_fwd_op;
  logic [ADDR_WIDTH-1:0]   w_back_op;
  logic [ADDR_WIDTH-1:0]   w_burst_next;
  logic [BURST_WIDTH-1:0]  w_burst_len;

`ifdef DC_STRIDE_EN
  logic [STRIDE_WIDTH-1:0] r_stride [DC_COUNT];
  logic [STRIDE_WIDTH-1:0] w_stride_load;

  // A zero stride would freeze the counter, so it is stored as 1.
  assign w_stride_load = (op_data[STRIDE_WIDTH-1:0] == {STRIDE_WIDTH{1'b0}}) ?
                         {{(STRIDE_WIDTH-1){1'b0}}, 1'b1} : op_data[STRIDE_WIDTH-1:0];
  assign w_step_op     = ADDR_WIDTH'(r_stride[op_sel]);
  assign w_step_burst  = ADDR_WIDTH'(r_stride[r_sel]);
`else
  assign w_step_op     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign w_step_burst  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`endif

  // The index is widened so that the range test stays meaningful when DC_COUNT is a power of two.
  assign w_sel_ok     = (32'(op_sel) < 32'(DC_COUNT));
  assign w_dc_op      = r_dc[op_sel];
  assign w_fwd_op     = w_dc_op + w_step_op;     // wraps modulo 2^ADDR_WIDTH
  assign w_back_op    = w_dc_op - w_step_op;
  assign w_burst_next = r_dc[r_sel] + w_step_burst;
  assign w_burst_len  = op_data[BURST_WIDTH-1:0];

  // Outputs are driven directly from registers. Only op_ready is gated by reset.
  assign op_ready      = (r_state == S_IDLE) && !reset;
  assign mem_req_valid = r_req_valid;
  assign mem_req_write = r_req_write;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wdata = r_req_wdata;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign dc_dir        = r_dir;
  assign dc_mod        = r_mod;

  for (genvar g = 0; g < DC_COUNT; g++) begin : g_dc_pack
    assign dc_addr[g*ADDR_WIDTH +: ADDR_WIDTH] = r_dc[g];
  end

  // Sequencer FSM: accepts operations, updates counters, and issues and tracks memory requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_dir       <= '0;
      r_mod       <= '0;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_burst_cnt <= '0;
      r_sel       <= '0;
      for (int i = 0; i < DC_COUNT; i++) begin
        r_dc[i] <= '0;
`ifdef DC_STRIDE_EN
        r_stride[i] <= {{(STRIDE_WIDTH-1){1'b0}}, 1'b1};
`endif
      end
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (op_valid && w_sel_ok) begin
            r_sel <= op_sel;
            case (op_code)
              OP_READ: begin
                r_dc[op_sel] <= w_fwd_op;
                r_req_addr   <= w_fwd_op;
                r_req_write  <= 1'b0;
                r_req_valid  <= 1'b1;
                r_burst_cnt  <= '0;
                r_state      <= S_REQ;
              end
              OP_WRITE: begin
                // A backward counter pre-decrements; a forward counter post-increments.
                r_req_addr   <= r_dir[op_sel] ? w_back_op : w_dc_op;
                r_dc[op_sel] <= r_dir[op_sel] ? w_back_op : w_fwd_op;
                r_req_wdata  <= op_data;
                r_req_write  <= 1'b1;
                r_req_valid  <= 1'b1;
                r_burst_cnt  <= '0;
                r_state      <= S_REQ;
              end
              OP_SETF, OP_SETB: begin
                r_dc[op_sel]  <= op_addr;
                r_dir[op_sel] <= (op_code == OP_SETB);
                r_mod[op_sel] <= 1'b1;
`ifdef DC_STRIDE_EN
                r_stride[op_sel] <= w_stride_load;
`endif
              end
              OP_RREAD, OP_RWRITE: begin
                r_req_addr  <= op_addr;
                r_req_wdata <= op_data;
                r_req_write <= (op_code == OP_RWRITE);
                r_req_valid <= 1'b1;
                r_burst_cnt <= '0;
                r_state     <= S_REQ;
              end
              OP_BURST: begin
                if (w_burst_len != {BURST_WIDTH{1'b0}}) begin
                  r_dc[op_sel] <= w_fwd_op;
                  r_req_addr   <= w_fwd_op;
                  r_req_write  <= 1'b0;
                  r_req_valid  <= 1'b1;
                  r_burst_cnt  <= w_burst_len - BURST_WIDTH'(1);
                  r_state      <= S_REQ;
                end else begin
                  r_burst_cnt <= '0;
                end
              end
              OP_NOP:  r_burst_cnt <= '0;
              default: r_burst_cnt <= '0;
            endcase
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_req_write ? S_IDLE : S_RSP;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_RSP: begin
          if (mem_rsp_valid) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= mem_rsp_data;
            if (r_burst_cnt != {BURST_WIDTH{1'b0}}) begin
              r_dc[r_sel] <= w_burst_next;
              r_req_addr  <= w_burst_next;
              r_req_valid <= 1'b1;
              r_burst_cnt <= r_burst_cnt - BURST_WIDTH'(1);
              r_state     <= S_REQ;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_RSP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dc_sequencer.sv
module tb_mem_dc_sequencer;
  localparam int AW  = 16;
  localparam int WW  = 32;
  localparam int DCN = 4;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [2:0]        op_code = 3'd0;
  logic [SW-1:0]     op_sel = '0;
  logic [AW-1:0]     op_addr = '0;
  logic [WW-1:0]     op_data = '0;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_req_write;
  logic [AW-1:0]     mem_req_addr;
  logic [WW-1:0]     mem_req_wdata;
  logic              mem_rsp_valid = 1'b0;
  logic [WW-1:0]     mem_rsp_data = '0;
  logic              rd_valid;
  logic [WW-1:0]     rd_data;
  logic [DCN*AW-1:0] dc_addr;
  logic [DCN-1:0]    dc_dir;
  logic [DCN-1:0]    dc_mod;

  int checks = 0;
  int errors = 0;

  // Reference model: plain per-counter integers and a queue of expected memory accesses.
  int m_dc [DCN];
  bit m_dir [DCN];
  bit m_mod [DCN];
  int m_stride [DCN];

  typedef struct packed {
    bit        wr;
    bit [15:0] addr;
    bit [31:0] wdata;
  } acc_t;
  acc_t exp_q[$];

  mem_dc_sequencer dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_sel(op_sel),
    .op_addr(op_addr), .op_data(op_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .dc_addr(dc_addr), .dc_dir(dc_dir), .dc_mod(dc_mod)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DCN; i++) begin
      m_dc[i] = 0; m_dir[i] = 0; m_mod[i] = 0; m_stride[i] = 1;
    end
    exp_q.delete();
  endtask

  function automatic int step_of(input int sel);
`ifdef DC_STRIDE_EN
    return m_stride[sel];
`else
    return 1;
`endif
  endfunction

  // Applies one operation to the model and queues the memory accesses it implies.
  task automatic model_op(input int code, input int sel, input int addr, input bit [31:0] data);
    int s;
    s = step_of(sel);
    case (code)
      1: begin
        m_dc[sel] = (m_dc[sel] + s) & 16'hFFFF;
        exp_q.push_back('{1'b0, 16'(m_dc[sel]), 32'h0});
      end
      2: begin
        if (m_dir[sel]) begin
          m_dc[sel] = (m_dc[sel] - s) & 16'hFFFF;
          exp_q.push_back('{1'b1, 16'(m_dc[sel]), data});
        end else begin
          exp_q.push_back('{1'b1, 16'(m_dc[sel]), data});
          m_dc[sel] = (m_dc[sel] + s) & 16'hFFFF;
        end
      end
      3, 4: begin
        m_dc[sel]  = addr & 16'hFFFF;
        m_dir[sel] = (code == 4);
        m_mod[sel] = 1;
        m_stride[sel] = ((data & 32'hF) == 0) ? 1 : int'(data & 32'hF);
      end
      5: exp_q.push_back('{1'b0, 16'(addr), 32'h0});
      6: exp_q.push_back('{1'b1, 16'(addr), data});
      7: begin
        for (int n = 0; n < int'(data & 32'hFF); n++) begin
          m_dc[sel] = (m_dc[sel] + s) & 16'hFFFF;
          exp_q.push_back('{1'b0, 16'(m_dc[sel]), 32'h0});
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    logic [DCN*AW-1:0] e_addr;
    logic [DCN-1:0]    e_dir;
    logic [DCN-1:0]    e_mod;
    for (int i = 0; i < DCN; i++) begin
      e_addr[i*AW +: AW] = 16'(m_dc[i]);
      e_dir[i] = m_dir[i];
      e_mod[i] = m_mod[i];
    end
    chk({tag, "_dc_addr"}, 64'(dc_addr), 64'(e_addr));
    chk({tag, "_dc_dir"}, 64'(dc_dir), 64'(e_dir));
    chk({tag, "_dc_mod"}, 64'(dc_mod), 64'(e_mod));
  endtask

  // Issues one operation and acts as the memory until the sequencer is idle again.
  task automatic run_op(input int code, input int sel, input int addr, input bit [31:0] data,
                        input int stall);
    acc_t a;
    bit [31:0] rdat;
    @(negedge clk);
    chk("op_ready_before", 64'(op_ready), 64'd1);
    op_valid = 1'b1; op_code = 3'(code); op_sel = SW'(sel);
    op_addr = AW'(addr); op_data = data;
    model_op(code, sel, addr, data);
    @(negedge clk);
    op_valid = 1'b0; op_code = 3'($urandom_range(0, 7)); op_data = $urandom;
    if (exp_q.size() == 0) begin
      chk("no_req", 64'(mem_req_valid), 64'd0);
      chk("ready_after_noop", 64'(op_ready), 64'd1);
    end
    while (exp_q.size() > 0) begin
      a = exp_q.pop_front();
      chk("req_valid", 64'(mem_req_valid), 64'd1);
      chk("req_write", 64'(mem_req_write), 64'(a.wr));
      chk("req_addr", 64'(mem_req_addr), 64'(a.addr));
      if (a.wr) chk("req_wdata", 64'(mem_req_wdata), 64'(a.wdata));
      // A response strobe while the request is still pending must be ignored.
      for (int s = 0; s < stall; s++) begin
        mem_rsp_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("stall_valid", 64'(mem_req_valid), 64'd1);
        chk("stall_addr", 64'(mem_req_addr), 64'(a.addr));
        chk("stall_no_rd", 64'(rd_valid), 64'd0);
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("req_dropped", 64'(mem_req_valid), 64'd0);
      if (a.wr) begin
        chk("ready_after_wr", 64'(op_ready), 64'd1);
      end else begin
        chk("busy_in_rsp", 64'(op_ready), 64'd0);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          @(negedge clk);
          chk("rsp_wait_no_rd", 64'(rd_valid), 64'd0);
        end
        rdat = $urandom;
        mem_rsp_valid = 1'b1; mem_rsp_data = rdat;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_data", 64'(rd_data), 64'(rdat));
        chk("ready_after_rsp", 64'(op_ready), 64'(exp_q.size() == 0));
      end
    end
    check_state("state");
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("in_reset_ready", 64'(op_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(op_ready), 64'd1);
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(mem_req_addr), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    check_state("rst");

    // 1: forward read
    run_op(3, 2, 16'h0100, 32'h0, 0);
    run_op(1, 2, 0, 32'h0, 0);
    chk("t1_dc2", 64'(dc_addr[47:32]), 64'h0101);
    chk("t1_mod2", 64'(dc_mod[2]), 64'd1);

    // 2: backward write pre-decrements
    run_op(4, 1, 16'h0010, 32'h0, 0);
    run_op(2, 1, 0, 32'hDEADBEEF, 1);
    chk("t2_dc1", 64'(dc_addr[31:16]), 64'h000F);
    chk("t2_dir1", 64'(dc_dir[1]), 64'd1);

    // 3: three-beat burst with a two-cycle stall per beat
    run_op(3, 0, 16'h0FFE, 32'h0, 0);
    run_op(7, 0, 0, 32'd3, 2);
    chk("t3_dc0", 64'(dc_addr[15:0]), 64'h1001);

    // 4: forward wrap and a zero-length burst
    run_op(3, 3, 16'hFFFF, 32'h0, 0);
    run_op(1, 3, 0, 32'h0, 0);
    chk("t4_dc3", 64'(dc_addr[63:48]), 64'h0000);
    run_op(7, 3, 0, 32'd0, 0);
    // backward wrap through a write from zero
    run_op(4, 3, 16'h0000, 32'h0, 0);
    run_op(2, 3, 0, 32'h12345678, 0);
    chk("t4_dc3_back", 64'(dc_addr[63:48]), 64'hFFFF);

    // absolute read/write leaves the counters untouched
    run_op(5, 0, 16'hABCD, 32'h0, 1);
    run_op(6, 1, 16'h4321, 32'hCAFEF00D, 0);
    run_op(0, 2, 16'h1111, 32'h0, 0);

`ifdef DC_STRIDE_EN
    // 6: per-counter stride
    run_op(3, 0, 16'h0020, 32'd4, 0);
    run_op(1, 0, 0, 32'h0, 0);
    run_op(1, 0, 0, 32'h0, 0);
    chk("t6_dc0", 64'(dc_addr[15:0]), 64'h0028);
    run_op(3, 0, 16'h0020, 32'd0, 0);
    run_op(1, 0, 0, 32'h0, 0);
    chk("t6_zero_stride", 64'(dc_addr[15:0]), 64'h0021);
`endif

    // randomized operation mix
    for (int k = 0; k < 40; k++) begin
      int code;
      code = int'($urandom_range(0, 7));
      run_op(code, int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)),
             (code == 7) ? 32'($urandom_range(0, 3)) : 32'($urandom),
             int'($urandom_range(0, 2)));
    end

    // 5: reset while waiting for the first response of a four-beat burst
    run_op(3, 0, 16'h0040, 32'h0, 0);
    @(negedge clk);
    op_valid = 1'b1; op_code = 3'd7; op_sel = 2'd0; op_data = 32'd4;
    @(negedge clk);
    op_valid = 1'b0;
    chk("t5_req", 64'(mem_req_valid), 64'd1);
    chk("t5_req_addr", 64'(mem_req_addr), 64'h0041);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("t5_async_req_valid", 64'(mem_req_valid), 64'd0);
    chk("t5_async_req_addr", 64'(mem_req_addr), 64'd0);
    chk("t5_async_ready", 64'(op_ready), 64'd0);
    check_state("t5_async");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h55AA55AA;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("t5_late_rsp_ignored", 64'(rd_valid), 64'd0);
    chk("t5_no_req", 64'(mem_req_valid), 64'd0);
    chk("t5_ready", 64'(op_ready), 64'd1);
    check_state("t5_post");
    run_op(1, 0, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
